// File: rtl/pixel_readout_pkg.sv
// Shared definitions for the pixel readout controller: matrix geometry,
// FIFO sizing, the encoder read-to-valid latency and the FSM state type.
package pixel_readout_pkg;

    localparam int NPIX       = 128;
    localparam int AW         = $clog2(NPIX);
    localparam int FIFO_DEPTH = 16;
    localparam int CW         = $clog2(NPIX + 1);

    // Cycles from a read strobe to the encoder presenting valid/addr. The
    // ISSUE -> CAPTURE step of the controller is built around this being 1.
    localparam int RD_LATENCY = 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        DONE
    } rd_state_e;

endpackage

// File: rtl/pixel_readout_ctrl_if.sv
// Readout bus: encoder request/response (read, valid, addr) plus the
// downstream address stream (out_valid, out_addr, out_ready).
// master = the readout controller, slave = encoder and downstream side.
interface pixel_readout_ctrl_if;
    import pixel_readout_pkg::*;

    logic          read;
    logic          valid;
    logic [AW-1:0] addr;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic          out_ready;

    modport master (
        output read,
        input  valid,
        input  addr,
        output out_valid,
        output out_addr,
        input  out_ready
    );

    modport slave (
        input  read,
        output valid,
        output addr,
        input  out_valid,
        input  out_addr,
        output out_ready
    );

endinterface

// File: rtl/pixel_addr_fifo.sv
// Synchronous first-word-fall-through FIFO for hit addresses. The head
// entry is visible on o_data whenever the FIFO is not empty (0 when empty).
// Push and pop in the same cycle are allowed at any fill level; the caller
// must not push into a full FIFO unless it is popping in the same cycle.
module pixel_addr_fifo #(
    parameter  int WIDTH = 7,
    parameter  int DEPTH = 16,
    localparam int PW    = $clog2(DEPTH),
    localparam int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNTW-1:0]  o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CNTW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNTW'(DEPTH));
    assign o_count   = r_count;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push;
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; emptiness is tracked
        // by r_count and o_data is forced to 0 while empty, so stale contents are
        // never observed.
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/pixel_readout_ctrl.sv
// Pixel readout controller: per frame, strobes the priority encoder, captures
// each returned hit address into an FWFT FIFO and reports the hit count.
// Optional build macro PIXEL_READOUT_HITMAP_EN adds a per-frame hitmap output.
module pixel_readout_ctrl
    import pixel_readout_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    pixel_readout_ctrl_if.master bus,
    output logic                 busy,
    output logic                 frame_done,
    output logic [CW-1:0]        hit_count,
    output logic                 overflow
`ifdef PIXEL_READOUT_HITMAP_EN
    ,
    output logic [NPIX-1:0]      hitmap
`endif
);

    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    rd_state_e       r_state;
    rd_state_e       w_next_state;
    logic [CW-1:0]   r_counter;
    logic [CW-1:0]   r_hit_count;
    logic            r_overflow;
    logic [CW-1:0]   w_counter_inc;
    logic            w_last_hit;
    logic            w_start;
    logic            w_read;
    logic            w_push;
    logic            w_push_en;
    logic            w_space;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [FCW-1:0]  w_fifo_count;

    assign w_counter_inc = r_counter + CW'(1);
    assign w_last_hit    = (w_counter_inc == CW'(NPIX));
    assign w_start       = (r_state == IDLE) && frame_start;
    // Space is reserved before the read, so the capture that follows always fits.
    assign w_space       = (w_fifo_count < FCW'(FIFO_DEPTH));
    assign w_push_en     = w_push && !w_fifo_full;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state decode plus the read strobe and push request.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_next_state = r_state;
        w_read       = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            IDLE: begin
                if (frame_start) w_next_state = ISSUE;
            end
            ISSUE: begin
                if (w_space) begin
                    w_read       = 1'b1;
                    w_next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                if (bus.valid) begin
                    w_push       = 1'b1;
                    w_next_state = w_last_hit ? DONE : ISSUE;
                end else begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Running hit counter, published count on entry to DONE, sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_counter   <= '0;
            r_hit_count <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_start)        r_counter <= '0;
            else if (w_push_en) r_counter <= w_counter_inc;
            if (r_state == CAPTURE && w_next_state == DONE)
                r_hit_count <= bus.valid ? w_counter_inc : r_counter;
            if (w_push_en && w_last_hit) r_overflow <= 1'b1;
        end
    end

`ifdef PIXEL_READOUT_HITMAP_EN
    logic [NPIX-1:0] r_hitmap;

    // Frame image: cleared on an accepted frame start, one bit set per capture.
    always_ff @(posedge clk) begin
        if (reset)          r_hitmap <= '0;
        else if (w_start)   r_hitmap <= '0;
        else if (w_push_en) r_hitmap[bus.addr] <= 1'b1;
    end

    assign hitmap = r_hitmap;
`endif

    pixel_addr_fifo #(
        .WIDTH (AW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push_en),
        .i_data  (bus.addr),
        .i_pop   (bus.out_ready),
        .o_data  (bus.out_addr),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign bus.read      = w_read;
    assign bus.out_valid = !w_fifo_empty;
    assign busy          = (r_state != IDLE);
    assign frame_done    = (r_state == DONE);
    assign hit_count     = r_hit_count;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Self-checking bench for pixel_readout_ctrl. A behavioural priority encoder
// serves the injected hit pattern lowest pixel first; expected results come
// from the pattern itself (ascending address list, hit totals, timing rules).
`timescale 1ns/1ps
module tb_pixel_readout_ctrl;
    import pixel_readout_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_start;
    logic          busy;
    logic          frame_done;
    logic [CW-1:0] hit_count;
    logic          overflow;
`ifdef PIXEL_READOUT_HITMAP_EN
    logic [NPIX-1:0] hitmap;
`endif

    pixel_readout_ctrl_if bus ();

    pixel_readout_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .bus         (bus.master),
        .busy        (busy),
        .frame_done  (frame_done),
        .hit_count   (hit_count),
        .overflow    (overflow)
`ifdef PIXEL_READOUT_HITMAP_EN
        ,
        .hitmap      (hitmap)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [NPIX-1:0] got, input logic [NPIX-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cycle counter and frame bookkeeping.
    int              cyc = 0;
    int              fs_cyc;
    int              n_reads;
    int              n_done;
    int              n_outv;
    int              done_rel;
    logic [CW-1:0]   done_hc;
    int              read_rel[$];
    logic [AW-1:0]   got_q[$];
    logic [NPIX-1:0] enc_pix;
    bit              ovf_exp;
    bit              rand_ready;

    always @(posedge clk) cyc = cyc + 1;

    // Behavioural encoder: a read returns the lowest pending pixel and clears it.
    always @(negedge clk) begin
        int idx;
        if (bus.read === 1'b1) begin
            idx = -1;
            for (int i = NPIX - 1; i >= 0; i--) if (enc_pix[i]) idx = i;
            if (idx >= 0) begin
                bus.valid    = 1'b1;
                bus.addr     = AW'(idx);
                enc_pix[idx] = 1'b0;
            end else begin
                bus.valid = 1'b0;
                bus.addr  = AW'($urandom);
            end
        end
    end

    // Observer: reads, frame completions, pops.
    always @(negedge clk) begin
        if (bus.read === 1'b1) begin
            n_reads++;
            read_rel.push_back(cyc - fs_cyc);
        end
        if (frame_done === 1'b1) begin
            n_done++;
            done_rel = cyc - fs_cyc;
            done_hc  = hit_count;
        end
        if (bus.out_valid === 1'b1) n_outv++;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) got_q.push_back(bus.out_addr);
    end

    // Random downstream back-pressure.
    always @(posedge clk) begin
        #2;
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [NPIX-1:0] pat);
        enc_pix  = pat;
        n_reads  = 0;
        n_done   = 0;
        n_outv   = 0;
        done_rel = -1;
        read_rel.delete();
        got_q.delete();
        frame_start = 1'b1;
        fs_cyc      = cyc;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (n_done == 0 && k < budget) begin
            tick();
            k++;
        end
        check({tag, ".done_seen"}, (n_done != 0), 1);
    endtask

    task automatic drain();
        rand_ready    = 1'b0;
        tick();
        bus.out_ready = 1'b1;
        tick(FIFO_DEPTH + 4);
    endtask

    // Compare a completed, drained frame against the pattern-derived model.
    task automatic check_frame(input string tag, input logic [NPIX-1:0] pat, input bit timing);
        int hits;
        int exp_q[$];
        hits = $countones(pat);
        for (int i = 0; i < NPIX; i++) if (pat[i]) exp_q.push_back(i);
        if (hits == NPIX) ovf_exp = 1'b1;
        check({tag, ".hit_count"}, done_hc, hits);
        check({tag, ".hc_held"}, hit_count, hits);
        check({tag, ".n_reads"}, n_reads, (hits == NPIX) ? NPIX : hits + 1);
        check({tag, ".n_done"}, n_done, 1);
        check({tag, ".n_pops"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, ".order"}, got_q[i], exp_q[i]);
        check({tag, ".overflow"}, overflow, ovf_exp);
        check({tag, ".drained"}, bus.out_valid, 0);
        check({tag, ".idle"}, busy, 0);
        if (timing) begin
            check({tag, ".latency"}, done_rel, (hits == NPIX) ? 2 * NPIX + 1 : 2 * hits + 3);
            for (int k = 0; k < read_rel.size(); k++)
                check({tag, ".read_cyc"}, read_rel[k], 2 * k + 1);
        end
`ifdef PIXEL_READOUT_HITMAP_EN
        check({tag, ".hitmap"}, hitmap, pat);
`endif
    endtask

    function automatic logic [NPIX-1:0] rand_pat(input int dens);
        logic [NPIX-1:0] p;
        for (int i = 0; i < NPIX; i++) p[i] = ($urandom_range(0, 99) < dens);
        return p;
    endfunction

    initial begin
        logic [NPIX-1:0] pat;
        int k;

        reset         = 1'b1;
        frame_start   = 1'b0;
        bus.valid     = 1'b0;
        bus.addr      = '0;
        bus.out_ready = 1'b1;
        rand_ready    = 1'b0;
        enc_pix       = '0;
        ovf_exp       = 1'b0;
        tick(3);
        check("rst.read", bus.read, 0);
        check("rst.busy", busy, 0);
        check("rst.frame_done", frame_done, 0);
        check("rst.hit_count", hit_count, 0);
        check("rst.out_valid", bus.out_valid, 0);
        check("rst.out_addr", bus.out_addr, 0);
        check("rst.overflow", overflow, 0);
        reset = 1'b0;
        tick(2);

        // Three hits, no back-pressure.
        pat = '0;
        pat[3] = 1'b1; pat[64] = 1'b1; pat[127] = 1'b1;
        start_frame(pat);
        wait_done("three", 40);
        drain();
        check_frame("three", pat, 1);

        // Empty frame.
        start_frame('0);
        wait_done("empty", 20);
        drain();
        check_frame("empty", '0, 1);
        check("empty.no_out_valid", n_outv, 0);

        // Twenty hits against a stalled consumer.
        pat = '0;
        while ($countones(pat) < 20) pat[$urandom_range(0, NPIX - 1)] = 1'b1;
        bus.out_ready = 1'b0;
        start_frame(pat);
        tick(80);
        check("bp.stall_reads", n_reads, FIFO_DEPTH);
        check("bp.busy", busy, 1);
        check("bp.no_done", n_done, 0);
        check("bp.out_valid", bus.out_valid, 1);
        for (int i = NPIX - 1; i >= 0; i--) if (pat[i]) k = i;
        check("bp.head", bus.out_addr, k);
        bus.out_ready = 1'b1;
        wait_done("bp", 200);
        drain();
        check_frame("bp", pat, 0);

        // frame_start pulsed mid-frame must be ignored.
        pat = rand_pat(8) | 128'h1;
        start_frame(pat);
        tick(5);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wait_done("ign", 400);
        drain();
        tick(5);
        check_frame("ign", pat, 1);

        // Every pixel hit: overflow, no 129th read.
        pat = '1;
        start_frame(pat);
        wait_done("full", 400);
        drain();
        check_frame("full", pat, 1);

        // Random patterns under random back-pressure; overflow must stay sticky.
        for (int f = 0; f < 6; f++) begin
            pat = rand_pat($urandom_range(0, 40));
            rand_ready = 1'b1;
            start_frame(pat);
            wait_done("rand", 2000);
            drain();
            check_frame("rand", pat, 0);
        end

        // Reset in CAPTURE after five captured hits.
        pat = rand_pat(20) | 128'hff;
        bus.out_ready = 1'b0;
        start_frame(pat);
        k = 0;
        while (n_reads < 6 && k < 60) begin
            tick();
            k++;
        end
        check("mrst.reached", n_reads, 6);
        reset = 1'b1;
        tick();
        check("mrst.read", bus.read, 0);
        check("mrst.busy", busy, 0);
        check("mrst.out_valid", bus.out_valid, 0);
        check("mrst.overflow", overflow, 0);
        check("mrst.hit_count", hit_count, 0);
        reset         = 1'b0;
        ovf_exp       = 1'b0;
        bus.out_ready = 1'b1;
        tick(2);

        // Normal frame after the mid-frame reset.
        pat = rand_pat(15);
        start_frame(pat);
        wait_done("post", 400);
        drain();
        check_frame("post", pat, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
